// File: rtl/bin_pkg.sv
// Shared definitions for the binarization job sequencer: threshold width and
// default, phase_done bit positions, state encoding and a busy decode helper.
package bin_pkg;

    localparam int THRES_W = 8;
    localparam logic [THRES_W-1:0] DEFAULT_THRES = THRES_W'(5);

    // Bit positions inside phase_done (condition_led from the datapath).
    localparam int PD_INT = 0;
    localparam int PD_BIN = 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INT_PULSE = 3'd1,
        ST_INT_WAIT  = 3'd2,
        ST_BIN_PULSE = 3'd3,
        ST_BIN_WAIT  = 3'd4,
        ST_DONE      = 3'd5,
        ST_ERROR     = 3'd6
    } state_t;

    // A job is in flight in any pulse or wait state.
    function automatic logic is_busy(state_t s);
        return (s == ST_INT_PULSE) || (s == ST_INT_WAIT) ||
               (s == ST_BIN_PULSE) || (s == ST_BIN_WAIT);
    endfunction

endpackage

// File: rtl/bin_sequencer_if.sv
// Control/status bundle between the user side and the binarization datapath.
// master drives start/abort/threshold/phase_done; slave is the sequencer.
interface bin_sequencer_if;
    import bin_pkg::*;

    logic               start;
    logic               abort;
    logic [THRES_W-1:0] thres_in;
    logic [1:0]         phase_done;
    logic               int_ctrl;
    logic               bin_ctrl;
    logic [THRES_W-1:0] thres_length;
    logic               busy;
    logic               done;
    logic               error;

    modport master (
        output start, abort, thres_in, phase_done,
        input  int_ctrl, bin_ctrl, thres_length, busy, done, error
    );

    modport slave (
        input  start, abort, thres_in, phase_done,
        output int_ctrl, bin_ctrl, thres_length, busy, done, error
    );

endinterface

// File: rtl/bin_phase_timer.sv
// Shared up-counter for control pulse length and phase timeout. Cleared by the
// FSM on every state change; saturates instead of wrapping.
module bin_phase_timer #(
    parameter int PULSE_LEN     = 10,
    parameter int PHASE_TIMEOUT = 70000,
    parameter int CNT_W         = 17
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_pulse_end,
    output logic o_timeout
);

    // Terminal counts are one less than the lengths because the counter reads
    // 0 on the first cycle of a state.
    localparam logic [CNT_W-1:0] PULSE_TC   = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(PHASE_TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_sat;

    assign w_sat = &r_cnt;

    // Count every cycle, restart on clear, hold at all-ones.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (!w_sat) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_pulse_end = (r_cnt >= PULSE_TC);
    assign o_timeout   = (r_cnt >= TIMEOUT_TC);

endmodule

// File: rtl/bin_sequencer.sv
// Runs one binarization job: latch threshold, pulse int_ctrl, wait for the
// integral phase, pulse bin_ctrl, wait for the binarization phase, report.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_IDLE      | no job; start accepted
// ST_INT_PULSE | int_ctrl high for PULSE_LEN cycles
// ST_INT_WAIT  | waiting for phase_done[PD_INT] rising edge (or sticky)
// ST_BIN_PULSE | bin_ctrl high for PULSE_LEN cycles
// ST_BIN_WAIT  | waiting for phase_done[PD_BIN] rising edge (or sticky)
// ST_DONE      | job finished; start re-arms, abort returns to idle
// ST_ERROR     | a phase timed out; start re-arms, abort returns to idle
module bin_sequencer
    import bin_pkg::*;
#(
    parameter int PULSE_LEN     = 10,
    parameter int PHASE_TIMEOUT = 70000,
    parameter int CNT_W         = 17
) (
    input  logic                  bin_clk,
    input  logic                  bin_rst,
    bin_sequencer_if.slave        bus
);

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_pd_prev;
    logic [1:0]         r_sticky;
    logic [1:0]         w_edge;
    logic [THRES_W-1:0] r_thres;
    logic               r_int_ctrl;
    logic               r_bin_ctrl;
    logic               r_busy;
    logic               r_done;
    logic               r_error;
    logic               w_accept;
    logic               w_cnt_clr;
    logic               w_pulse_end;
    logic               w_timeout;

    // prev is loaded every cycle, so a level already high when a job is
    // accepted never looks like an edge on the following cycle.
    assign w_edge    = bus.phase_done & ~r_pd_prev;
    assign w_accept  = !is_busy(r_state) && bus.start && !bus.abort;
    assign w_cnt_clr = (w_next != r_state);

    bin_phase_timer #(
        .PULSE_LEN     (PULSE_LEN),
        .PHASE_TIMEOUT (PHASE_TIMEOUT),
        .CNT_W         (CNT_W)
    ) u_timer (
        .i_clk       (bin_clk),
        .i_rst       (bin_rst),
        .i_clr       (w_cnt_clr),
        .o_pulse_end (w_pulse_end),
        .o_timeout   (w_timeout)
    );

    // Next-state decode; abort beats every other condition.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (w_accept)       w_next = ST_INT_PULSE;
                else if (bus.abort) w_next = ST_IDLE;
            end
            ST_INT_PULSE: begin
                if (bus.abort)        w_next = ST_IDLE;
                else if (w_pulse_end) w_next = ST_INT_WAIT;
            end
            ST_INT_WAIT: begin
                if (bus.abort)                                  w_next = ST_IDLE;
                else if (w_edge[PD_INT] || r_sticky[PD_INT])    w_next = ST_BIN_PULSE;
                else if (w_timeout)                             w_next = ST_ERROR;
            end
            ST_BIN_PULSE: begin
                if (bus.abort)        w_next = ST_IDLE;
                else if (w_pulse_end) w_next = ST_BIN_WAIT;
            end
            ST_BIN_WAIT: begin
                if (bus.abort)                                  w_next = ST_IDLE;
                else if (w_edge[PD_BIN] || r_sticky[PD_BIN])    w_next = ST_DONE;
                else if (w_timeout)                             w_next = ST_ERROR;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State, edge history, sticky edges, threshold and Moore outputs decoded
    // from the next state so every output is a flop.
    always_ff @(posedge bin_clk) begin
        if (bin_rst) begin
            r_state    <= ST_IDLE;
            r_pd_prev  <= '0;
            r_sticky   <= '0;
            r_thres    <= DEFAULT_THRES;
            r_int_ctrl <= 1'b0;
            r_bin_ctrl <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_pd_prev <= bus.phase_done;
            if (w_accept) begin
                r_thres  <= (bus.thres_in == '0) ? DEFAULT_THRES : bus.thres_in;
                r_sticky <= '0;
            end else begin
                // An early edge during a phase's own pulse is remembered so
                // its wait state can exit on the first cycle.
                if (r_state == ST_INT_PULSE && w_edge[PD_INT]) r_sticky[PD_INT] <= 1'b1;
                if (r_state == ST_BIN_PULSE && w_edge[PD_BIN]) r_sticky[PD_BIN] <= 1'b1;
            end
            r_int_ctrl <= (w_next == ST_INT_PULSE);
            r_bin_ctrl <= (w_next == ST_BIN_PULSE);
            r_busy     <= is_busy(w_next);
            r_done     <= (w_next == ST_DONE);
            r_error    <= (w_next == ST_ERROR);
        end
    end

    assign bus.int_ctrl     = r_int_ctrl;
    assign bus.bin_ctrl     = r_bin_ctrl;
    assign bus.thres_length = r_thres;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.error        = r_error;

endmodule

// File: tb/tb_bin_sequencer.sv
// Scoreboard bench for bin_sequencer: the stimulus process queues the events
// it expects; the monitor turns DUT output activity into events and compares.
module tb_bin_sequencer;

    typedef enum int {EV_INT, EV_BIN, EV_DONE, EV_ERR, EV_SNAP} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       a;
        int       b;
        int       c;
    } exp_t;

    bit   clk = 1'b0;
    logic rst;
    bit   tb_done;
    int   snap_seq;

    exp_t exp_q[$];

    bin_sequencer_if bus();

    bin_sequencer #(
        .PULSE_LEN     (10),
        .PHASE_TIMEOUT (100),
        .CNT_W         (17)
    ) dut (
        .bin_clk (clk),
        .bin_rst (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic int pack(bit ic, bit bc, bit bs, bit dn, bit er, logic [7:0] th);
        return {19'd0, ic, bc, bs, dn, er, th};
    endfunction

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(ev_kind_t k, int a, int b, int c);
        exp_q.push_back('{kind: k, a: a, b: b, c: c});
    endtask

    // Expect the outputs right after the next rising edge.
    task automatic expect_snap(bit ic, bit bc, bit bs, bit dn, bit er, logic [7:0] th);
        push_exp(EV_SNAP, 0, pack(ic, bc, bs, dn, er, th), 0);
        snap_seq++;
    endtask

    // Full job: integral phase done g cycles into INT_WAIT, binarization
    // phase done h cycles into BIN_WAIT.
    task automatic run_job(logic [7:0] th, logic [7:0] exp_th, int g, int h);
        push_exp(EV_INT, 10, int'(exp_th), 0);
        push_exp(EV_BIN, 10, int'(exp_th), g);
        push_exp(EV_DONE, 0, pack(0, 0, 0, 1, 0, exp_th), h);
        bus.thres_in = th;
        bus.start    = 1'b1;
        cyc(1);
        bus.start    = 1'b0;
        cyc(9 + g);
        bus.phase_done[0] = 1'b1;
        cyc(10 + h);
        bus.phase_done[1] = 1'b1;
        cyc(3);
    endtask

    // Job whose integral phase never completes.
    task automatic timeout_job(logic [7:0] th, logic [7:0] exp_th, logic [1:0] pd);
        push_exp(EV_INT, 10, int'(exp_th), 0);
        push_exp(EV_ERR, 0, pack(0, 0, 0, 0, 1, exp_th), 100);
        bus.phase_done = pd;
        bus.thres_in   = th;
        bus.start      = 1'b1;
        cyc(1);
        bus.start      = 1'b0;
        cyc(112);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.thres_in   = 8'd0;
        bus.phase_done = 2'b00;
        rst            = 1'b1;
        tb_done        = 1'b0;
        snap_seq       = 0;

        @(negedge clk);
        expect_snap(0, 0, 0, 0, 0, 8'd5);
        cyc(2);
        rst = 1'b0;
        cyc(1);

        // Normal run: 20 cycles in INT_WAIT, 30 in BIN_WAIT.
        run_job(8'd5, 8'd5, 20, 30);

        // Re-arm from DONE with a new threshold.
        bus.phase_done = 2'b00;
        cyc(2);
        run_job(8'd200, 8'd200, 3, 5);

        // Zero threshold falls back to default; integral phase times out.
        bus.phase_done = 2'b00;
        cyc(2);
        timeout_job(8'd0, 8'd5, 2'b00);

        // Both done bits already high at start: no edge, timeout again.
        timeout_job(8'd7, 8'd7, 2'b11);

        // Early integral edge during INT_PULSE: INT_WAIT lasts one cycle.
        bus.phase_done = 2'b00;
        cyc(2);
        push_exp(EV_INT, 10, 9, 0);
        push_exp(EV_BIN, 10, 9, 1);
        push_exp(EV_DONE, 0, pack(0, 0, 0, 1, 0, 8'd9), 5);
        bus.thres_in = 8'd9;
        bus.start    = 1'b1;
        cyc(1);
        bus.start    = 1'b0;
        cyc(3);
        bus.phase_done[0] = 1'b1;
        cyc(22);
        bus.phase_done[1] = 1'b1;
        cyc(3);

        // Abort on the 4th bin_ctrl cycle.
        bus.phase_done = 2'b00;
        cyc(2);
        push_exp(EV_INT, 10, 33, 0);
        push_exp(EV_BIN, 4, 33, 2);
        bus.thres_in = 8'd33;
        bus.start    = 1'b1;
        cyc(1);
        bus.start    = 1'b0;
        cyc(11);
        bus.phase_done[0] = 1'b1;
        cyc(4);
        bus.abort = 1'b1;
        expect_snap(0, 0, 0, 0, 0, 8'd33);
        cyc(1);
        bus.abort = 1'b0;
        cyc(2);

        // start and abort together in IDLE: nothing launches.
        bus.thres_in = 8'd77;
        bus.start    = 1'b1;
        bus.abort    = 1'b1;
        expect_snap(0, 0, 0, 0, 0, 8'd33);
        cyc(1);
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        expect_snap(0, 0, 0, 0, 0, 8'd33);
        cyc(2);

        // start while busy is ignored; reset during BIN_WAIT.
        bus.phase_done = 2'b00;
        cyc(2);
        push_exp(EV_INT, 10, 44, 0);
        push_exp(EV_BIN, 10, 44, 3);
        bus.thres_in = 8'd44;
        bus.start    = 1'b1;
        cyc(1);
        bus.start    = 1'b0;
        cyc(4);
        bus.thres_in = 8'd99;
        bus.start    = 1'b1;
        cyc(1);
        bus.start    = 1'b0;
        cyc(7);
        bus.phase_done[0] = 1'b1;
        cyc(14);
        rst = 1'b1;
        expect_snap(0, 0, 0, 0, 0, 8'd5);
        cyc(1);
        rst = 1'b0;
        cyc(2);

        tb_done = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    // Monitor: samples 1 ns after each rising edge.
    int n_cmp = 0;
    int n_bad = 0;
    int int_run, bin_run, wait_cnt, gap_bin;
    int snap_done = 0;
    bit p_int, p_bin, p_done, p_err;

    task automatic check(ev_kind_t k, int a, int b, int c);
        exp_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: got a=%0d b=0x%0h c=%0d, want no event", k.name(), a, b, c);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.a != a || e.b != b || e.c != c) begin
                n_bad++;
                $display("FAIL %s: got %s a=%0d b=0x%0h c=%0d, want %s a=%0d b=0x%0h c=%0d",
                         e.kind.name(), k.name(), a, b, c, e.kind.name(), e.a, e.b, e.c);
            end
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            int_run  = 0;
            bin_run  = 0;
            wait_cnt = 0;
            gap_bin  = 0;
        end else begin
            wait_cnt++;
            if (bus.int_ctrl) int_run++;
            if (bus.bin_ctrl) bin_run++;
            if (!bus.int_ctrl && p_int) begin
                check(EV_INT, int_run, int'(bus.thres_length), 0);
                int_run  = 0;
                wait_cnt = 0;
            end
            if (bus.bin_ctrl && !p_bin) gap_bin = wait_cnt;
            if (!bus.bin_ctrl && p_bin) begin
                check(EV_BIN, bin_run, int'(bus.thres_length), gap_bin);
                bin_run  = 0;
                wait_cnt = 0;
            end
            if (bus.done && !p_done)
                check(EV_DONE, 0, pack(bus.int_ctrl, bus.bin_ctrl, bus.busy, bus.done,
                                       bus.error, bus.thres_length), wait_cnt);
            if (bus.error && !p_err)
                check(EV_ERR, 0, pack(bus.int_ctrl, bus.bin_ctrl, bus.busy, bus.done,
                                      bus.error, bus.thres_length), wait_cnt);
        end
        if (snap_done != snap_seq) begin
            check(EV_SNAP, 0, pack(bus.int_ctrl, bus.bin_ctrl, bus.busy, bus.done,
                                   bus.error, bus.thres_length), 0);
            snap_done++;
        end
        p_int  = bus.int_ctrl;
        p_bin  = bus.bin_ctrl;
        p_done = bus.done;
        p_err  = bus.error;

        if (tb_done) begin
            while (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL %s missing: got no event, want a=%0d b=0x%0h c=%0d",
                         e.kind.name(), e.a, e.b, e.c);
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

endmodule
